// File: rtl/gf180mcu_fd_sc_mcu9t5v0__invpipe.sv
// Elastic registered inverter: WIDTH-bit beats inverted at capture and carried through DEPTH valid/ready stages.
// Optional per-bit polarity mask port POL enabled by macro GF180MCU_FD_SC_MCU9T5V0_INVPIPE_POL_EN.
module gf180mcu_fd_sc_mcu9t5v0__invpipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [WIDTH-1:0] I,
  input  logic             I_VLD,
  output logic             I_RDY,
  output logic [WIDTH-1:0] ZN,
  output logic             ZN_VLD,
  input  logic             ZN_RDY,
  output logic [CNTW-1:0]  CNT
`ifdef GF180MCU_FD_SC_MCU9T5V0_INVPIPE_POL_EN
  ,
  input  logic [WIDTH-1:0] POL
`endif
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [CNTW-1:0]  r_cnt;

  logic [DEPTH-1:0] w_adv;
  logic             w_irdy;
  logic             w_in;
  logic             w_out;
  logic [WIDTH-1:0] w_cap;

`ifdef GF180MCU_FD_SC_MCU9T5V0_INVPIPE_POL_EN
  assign w_cap = I ^ POL;
`else
  assign w_cap = ~I;
`endif

  // Ready ripples from the head back to stage 0; a stage may move if any stage ahead has room.
  always_comb begin
    logic room;
    room   = ZN_RDY;
    w_adv  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_adv[k] = r_vld[k] & room;
      room     = ~r_vld[k] | room;
    end
    w_irdy = room;
  end

  assign w_in   = I_VLD & w_irdy;
  assign w_out  = w_adv[DEPTH-1];
  assign I_RDY  = w_irdy;
  assign ZN     = r_data[DEPTH-1];
  assign ZN_VLD = r_vld[DEPTH-1];
  assign CNT    = r_cnt;

  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_vld <= '0;
      r_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) r_data[k] <= '0;
    end else begin
      if (w_in) r_data[0] <= w_cap;
      r_vld[0] <= w_in | (r_vld[0] & ~w_adv[0]);
      for (int k = 1; k < DEPTH; k++) begin
        if (w_adv[k-1]) r_data[k] <= r_data[k-1];
        r_vld[k] <= w_adv[k-1] | (r_vld[k] & ~w_adv[k]);
      end
      case ({w_in, w_out})
        2'b10:   r_cnt <= r_cnt + CNTW'(1);
        2'b01:   r_cnt <= r_cnt - CNTW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__invpipe.sv
// Bench for the elastic inverter pipeline: directed scenarios then random traffic against a beat-position model.
module tb_gf180mcu_fd_sc_mcu9t5v0__invpipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CNTW  = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rn;
  logic [WIDTH-1:0] din;
  logic             ivld;
  logic             irdy;
  logic [WIDTH-1:0] zn;
  logic             znvld;
  logic             znrdy;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] pol;

  int checks   = 0;
  int failures = 0;

  gf180mcu_fd_sc_mcu9t5v0__invpipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(clk), .RN(rn), .I(din), .I_VLD(ivld), .I_RDY(irdy),
    .ZN(zn), .ZN_VLD(znvld), .ZN_RDY(znrdy), .CNT(cnt)
`ifdef GF180MCU_FD_SC_MCU9T5V0_INVPIPE_POL_EN
    , .POL(pol)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    int               pos;
  } beat_t;

  beat_t            q[$];
  logic [WIDTH-1:0] last_head;
  logic             known;
  logic             smp_irdy;
  int               accepted;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] mask();
`ifdef GF180MCU_FD_SC_MCU9T5V0_INVPIPE_POL_EN
    return pol;
`else
    return '1;
`endif
  endfunction

  // One clock: drive, check ready before the edge, advance the model, check state after the edge.
  task automatic cyc(input logic r, input logic v, input logic [WIDTH-1:0] d, input logic zr);
    logic m_in, m_out, m_rdy;
    int   limit;
    rn = r; ivld = v; din = d; znrdy = zr;
    #1;
    m_rdy    = (q.size() < DEPTH) || zr;
    smp_irdy = irdy;
    if (known && r) check("i_rdy", 64'(irdy), 64'(m_rdy));
    m_in  = v && m_rdy;
    m_out = zr && q.size() > 0 && q[0].pos == DEPTH - 1;
    if (m_in && r) accepted++;
    @(posedge clk);
    if (!r) begin
      q.delete();
      last_head = '0;
    end else begin
      if (m_out) void'(q.pop_front());
      limit = DEPTH - 1;
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].pos < limit) q[i].pos++;
        if (q[i].pos == DEPTH - 1) last_head = q[i].d;
        limit = q[i].pos - 1;
      end
      if (m_in) begin
        q.push_back('{d: d ^ mask(), pos: 0});
        if (DEPTH == 1) last_head = d ^ mask();
      end
    end
    known = 1'b1;
    #1;
    check("cnt", 64'(cnt), 64'(q.size()));
    check("zn_vld", 64'(znvld), 64'(q.size() > 0 && q[0].pos == DEPTH - 1));
    check("zn", 64'(zn), 64'(last_head));
  endtask

  initial begin
    known = 1'b0; last_head = '0; accepted = 0; pol = '1;
    rn = 1'b0; ivld = 1'b0; din = '0; znrdy = 1'b0;

    // Reset with a beat offered: nothing captured.
    repeat (2) begin
      cyc(1'b0, 1'b1, 8'hA5, 1'b1);
      check("rst_irdy", 64'(irdy), 64'd1);
      check("rst_cnt", 64'(cnt), 64'd0);
      check("rst_zn", 64'(zn), 64'd0);
    end

    // Streaming
    cyc(1'b1, 1'b1, 8'h00, 1'b1);
    cyc(1'b1, 1'b1, 8'h0F, 1'b1);
    check("stream_first", 64'(zn), 64'hFF);
    cyc(1'b1, 1'b1, 8'hA5, 1'b1);
    check("stream_second", 64'(zn), 64'hF0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    check("stream_third", 64'(zn), 64'h5A);
    repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b1);

    // Backpressure: three offered, two accepted
    accepted = 0;
    cyc(1'b1, 1'b1, 8'h11, 1'b0);
    cyc(1'b1, 1'b1, 8'h22, 1'b0);
    cyc(1'b1, 1'b1, 8'h33, 1'b0);
    check("bp_third_rdy", 64'(smp_irdy), 64'd0);
    check("bp_accepted", 64'(accepted), 64'd2);
    check("bp_hold", 64'(zn), 64'hEE);
    repeat (4) cyc(1'b1, 1'b0, 8'h00, 1'b1);

    // Full pipeline with simultaneous in/out
    cyc(1'b1, 1'b1, 8'h44, 1'b0);
    cyc(1'b1, 1'b1, 8'h55, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 8'(8'h60 + i), 1'b1);
      check("sim_rdy", 64'(smp_irdy), 64'd1);
      check("sim_cnt", 64'(cnt), 64'd2);
    end
    repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b1);

    // Reset while full and stalled: held beats vanish
    cyc(1'b1, 1'b1, 8'h77, 1'b0);
    cyc(1'b1, 1'b1, 8'h88, 1'b0);
    check("pre_rst_cnt", 64'(cnt), 64'd2);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("mid_rst_cnt", 64'(cnt), 64'd0);
    check("mid_rst_vld", 64'(znvld), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b1);
      check("post_rst_vld", 64'(znvld), 64'd0);
    end

`ifdef GF180MCU_FD_SC_MCU9T5V0_INVPIPE_POL_EN
    pol = 8'h0F;
    cyc(1'b1, 1'b1, 8'hFF, 1'b0);
    pol = 8'h00;
    repeat (2) cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check("pol_zn", 64'(zn), 64'hF0);
    check("pol_vld", 64'(znvld), 64'd1);
    repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b1);
`endif

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
`ifdef GF180MCU_FD_SC_MCU9T5V0_INVPIPE_POL_EN
      pol = 8'($urandom);
`endif
      cyc(($urandom_range(0, 49) != 0), 1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
